// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register map, bit positions, FSM encoding and default window
// shared by the UART receiver core and its bus-facing top level.
package uart_rx_pkg;

    // Register offsets within the window (address[1:0])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int STAT_AVAIL_BIT     = 0;
    localparam int STAT_OVERRUN_BIT   = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;
    localparam int STAT_COUNT_LSB     = 8;

    // CTRL bit positions
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_ERR_BIT = 1;

    // Default address window
    localparam logic [31:0] DEF_ENTRY_START = 32'h3fff_ffe0;
    localparam logic [31:0] DEF_ENTRY_END   = 32'h3fff_ffef;

    // Receive FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: RxD synchroniser, free-running oversample tick generator and
// the 8N1 receive FSM. Emits one-clk pulses for a good byte or a framing error.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 1500000,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int unsigned     TICK_INC  = BAUD * OVERSAMPLE;
    localparam int              OS_W      = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    logic            sync1_q;
    logic            rx_sync_q;
    logic [31:0]     acc_q, acc_d, acc_sum;
    logic            tick;
    rx_state_e       state_q, state_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_sample;

    // Phase accumulator: a tick whenever the accumulated rate crosses CLK_FREQ
    always_comb begin
        acc_sum = acc_q + TICK_INC;
        acc_d   = acc_sum;
        tick    = 1'b0;
        if (acc_sum >= CLK_FREQ) begin
            acc_d = acc_sum - CLK_FREQ;
            tick  = 1'b1;
        end
    end

    // Synchroniser, accumulator and receive datapath registers
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            acc_q     <= '0;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= rx_in;
            rx_sync_q <= sync1_q;
            acc_q     <= acc_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter/shift update logic
    // NOTE: every output gets a hold value first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d  = ST_START;
                    os_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (os_cnt_q == HALF_LAST) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        state_d  = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must return high before re-arming
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: stop-bit sample decides between a good byte and a framing error
    always_comb begin
        stop_sample = (state_q == ST_STOP) && tick && (os_cnt_q == OS_LAST);
        byte_valid  = stop_sample && rx_sync_q;
        frame_error = stop_sample && !rx_sync_q;
        rx_byte     = shift_q;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: bus-slave UART receiver. Wraps the receive core with a byte FIFO,
// sticky error flags and a DATA/STATUS/CTRL register window on the slave bus.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned BAUD        = 1500000,
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] ENTRY_START = DEF_ENTRY_START,
    parameter logic [31:0] ENTRY_END   = DEF_ENTRY_END
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] address,
    inout  wire  [31:0] data,
    input  logic        request,
    input  logic        r_w,
    output wire         ready_out,
    input  logic        RxD,
    output logic        rx_avail
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_error;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             sel_q, sel_d;

    logic             selected, empty, full;
    logic             pop, push, flush, clr_err, overrun_set, wr_ctrl;
    logic [31:0]      status_word, rd_data;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_core (
        .clk         (clk),
        .clr         (clr),
        .rx_in       (RxD),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .frame_error (frame_error)
    );

    // Bus decode and FIFO/flag control strobes; only a request's first cycle acts
    always_comb begin
        selected    = request && (address >= ENTRY_START) && (address <= ENTRY_END);
        sel_d       = selected;
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        pop         = selected && !r_w && (address[1:0] == REG_DATA) && !sel_q && !empty;
        wr_ctrl     = selected && r_w && (address[1:0] == REG_CTRL) && !sel_q;
        flush       = wr_ctrl && data[CTRL_FLUSH_BIT];
        clr_err     = wr_ctrl && data[CTRL_CLR_ERR_BIT];
        push        = byte_valid && (!full || pop) && !flush;
        overrun_set = byte_valid && full && !pop;
    end

    // FIFO pointer/count and sticky flag next-state; flush overrides push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        // A clear and a same-cycle new error: the new error survives
        overrun_d   = (clr_err ? 1'b0 : overrun_q)   | overrun_set;
        frame_err_d = (clr_err ? 1'b0 : frame_err_q) | frame_error;
    end

    // Control and status registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            sel_q       <= sel_d;
        end
    end

    // FIFO storage write port
    // NOTE: the byte array has no reset; count/head/tail gate every read, so
    // stale contents are never visible and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= rx_byte;
        end
    end

    // Register read mux (combinational, zero wait)
    always_comb begin
        status_word                             = '0;
        status_word[STAT_AVAIL_BIT]             = !empty;
        status_word[STAT_OVERRUN_BIT]           = overrun_q;
        status_word[STAT_FRAME_ERR_BIT]         = frame_err_q;
        status_word[STAT_COUNT_LSB +: 8]        = 8'(count_q);
        rd_data = '0;
        case (address[1:0])
            REG_DATA:   rd_data = empty ? 32'h0 : {24'h0, mem[head_q]};
            REG_STATUS: rd_data = status_word;
            default:    rd_data = '0;
        endcase
    end

    assign data      = (selected && !r_w) ? rd_data : 32'bz;
    assign ready_out = selected ? 1'b1 : 1'bz;
    assign rx_avail  = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A queue-based model of the
// receiver (bytes in, sticky flags) predicts every register read.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_FREQ   = 50000000;
    localparam int unsigned BAUD       = 1500000;
    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned DEPTH      = 16;
    localparam logic [31:0] WIN_START  = 32'h3fff_ffe0;
    localparam logic [31:0] WIN_END    = 32'h3fff_ffef;
    localparam logic [31:0] A_DATA     = WIN_START;
    localparam logic [31:0] A_STATUS   = WIN_START + 32'd1;
    localparam logic [31:0] A_CTRL     = WIN_START + 32'd2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] address = '0;
    logic        request = 1'b0;
    logic        r_w = 1'b0;
    logic        RxD = 1'b1;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_wdata = '0;
    wire  [31:0] data;
    wire         ready_out;
    wire         rx_avail;

    assign data = tb_drv ? tb_wdata : 32'bz;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int unsigned tick_period;

    // Reference model state
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_fe = 1'b0;

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OVERSAMPLE),
        .DEPTH       (DEPTH),
        .ENTRY_START (WIN_START),
        .ENTRY_END   (WIN_END)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .address   (address),
        .data      (data),
        .request   (request),
        .r_w       (r_w),
        .ready_out (ready_out),
        .RxD       (RxD),
        .rx_avail  (rx_avail)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge clr) begin
        if (!clr) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Clocks for bit k of a frame, spreading the fractional bit period evenly
    function automatic int bit_clocks(input int k);
        longint a, b;
        a = longint'(k + 1) * CLK_FREQ / BAUD;
        b = longint'(k) * CLK_FREQ / BAUD;
        return int'(a - b);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s = '0;
        s[0]    = (q.size() != 0);
        s[1]    = m_ovr;
        s[2]    = m_fe;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    // Serial frame on RxD; called and returns on a falling clock edge
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            RxD = bits[k];
            repeat (bit_clocks(k)) @(negedge clk);
        end
        RxD = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                 m_fe = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                       m_ovr = 1'b1;
    endtask

    task automatic send_and_model(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        model_frame(b, stop);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val, output logic rdy);
        address = addr;
        r_w     = 1'b0;
        request = 1'b1;
        #1;
        val = data;
        rdy = ready_out;
        @(negedge clk);
        request = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val);
        address  = addr;
        r_w      = 1'b1;
        tb_wdata = val;
        tb_drv   = 1'b1;
        request  = 1'b1;
        @(negedge clk);
        request = 1'b0;
        tb_drv  = 1'b0;
        r_w     = 1'b0;
        if (addr[1:0] == 2'd2 && addr >= WIN_START && addr <= WIN_END) begin
            if (val[0]) q.delete();
            if (val[1]) begin
                m_ovr = 1'b0;
                m_fe  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic read_data_chk(input string name);
        logic [31:0] v;
        logic [31:0] exp;
        logic rdy;
        exp = (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
        bus_read(A_DATA, v, rdy);
        check(name, v, exp);
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic read_status_chk(input string name);
        logic [31:0] v;
        logic rdy;
        bus_read(A_STATUS, v, rdy);
        check(name, v, model_status());
    endtask

    task automatic align_tick();
        while ((cyc % tick_period) != 0) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  val;
        logic        stop;
        logic [31:0] exp_status;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [31:0] v;
        logic        rdy;
        int          n;

        tick_period = CLK_FREQ / gcd(CLK_FREQ, BAUD * OVERSAMPLE);

        vecs[0] = '{8'hC3, 1'b1, 32'h0000_0101};
        vecs[1] = '{8'h81, 1'b0, 32'h0000_0105};
        vecs[2] = '{8'hFF, 1'b1, 32'h0000_0205};
        vecs[3] = '{8'h00, 1'b1, 32'h0000_0305};
        vecs[4] = '{8'h7E, 1'b1, 32'h0000_0405};

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_rx_avail", {31'h0, rx_avail}, 32'h0);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_rx_avail", {31'h0, rx_avail}, 32'h0);
        bus_read(A_STATUS, v, rdy);
        check("post_reset_status", v, 32'h0);
        check("ready_out_selected", {31'h0, rdy}, 32'h1);

        // Single byte 0x55
        send_and_model(8'h55, 1'b1);
        bus_read(A_STATUS, v, rdy);
        check("status_after_55", v, 32'h0000_0101);
        check("rx_avail_after_55", {31'h0, rx_avail}, 32'h1);
        bus_read(WIN_END, v, rdy);
        check("window_end_reads_zero", v, 32'h0);
        bus_read(A_CTRL, v, rdy);
        check("ctrl_reads_zero", v, 32'h0);
        bus_read(WIN_END + 32'd1, v, rdy);
        bus_read(WIN_START - 32'd4, v, rdy);
        read_status_chk("outside_window_no_pop");
        bus_read(A_DATA, v, rdy);
        check("data_55", v, 32'h0000_0055);
        void'(q.pop_front());
        bus_read(A_STATUS, v, rdy);
        check("status_empty_after_read", v, 32'h0);
        check("rx_avail_clear", {31'h0, rx_avail}, 32'h0);

        // Table of frames, status after each, then read back the good bytes
        foreach (vecs[i]) begin
            send_and_model(vecs[i].val, vecs[i].stop);
            bus_read(A_STATUS, v, rdy);
            check($sformatf("vec%0d_status", i), v, vecs[i].exp_status);
        end
        foreach (vecs[i]) begin
            if (vecs[i].stop) begin
                bus_read(A_DATA, v, rdy);
                check($sformatf("vec%0d_data", i), v, {24'h0, vecs[i].val});
                void'(q.pop_front());
            end
        end
        bus_write(A_CTRL, 32'h2);
        read_status_chk("vec_clear_status");

        // Overrun: 17 bytes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) send_and_model(8'(i), 1'b1);
        bus_read(A_STATUS, v, rdy);
        check("overrun_status", v, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, v, rdy);
            check($sformatf("overrun_data%0d", i), v, 32'(i));
            void'(q.pop_front());
        end
        bus_read(A_STATUS, v, rdy);
        check("overrun_drained_status", v, 32'h0000_0002);
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STATUS, v, rdy);
        check("overrun_cleared", v, 32'h0);

        // Quarter-bit glitch on idle line
        RxD = 1'b0;
        repeat (bit_clocks(0) / 4) @(negedge clk);
        RxD = 1'b1;
        repeat (2 * bit_clocks(0)) @(negedge clk);
        bus_read(A_STATUS, v, rdy);
        check("glitch_no_push", v, 32'h0);

        // Framing error, then a clean byte
        send_and_model(8'hA3, 1'b0);
        repeat (bit_clocks(0)) @(negedge clk);
        bus_read(A_STATUS, v, rdy);
        check("frame_err_status", v, 32'h0000_0004);
        send_and_model(8'h3C, 1'b1);
        bus_read(A_STATUS, v, rdy);
        check("after_ferr_status", v, 32'h0000_0105);
        bus_write(A_STATUS, 32'h3);
        bus_write(A_DATA, 32'h3);
        read_status_chk("write_other_offsets_ignored");
        read_data_chk("after_ferr_data_3c");
        bus_write(A_CTRL, 32'h2);
        read_status_chk("ferr_cleared");

        // Held DATA read pops exactly once
        send_and_model(8'h11, 1'b1);
        send_and_model(8'h22, 1'b1);
        address = A_DATA;
        r_w     = 1'b0;
        request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i == 0) check("held_read_first_value", data, 32'h0000_0011);
            check($sformatf("held_read_ready%0d", i), {31'h0, ready_out}, 32'h1);
            @(negedge clk);
        end
        request = 1'b0;
        @(negedge clk);
        void'(q.pop_front());
        bus_read(A_STATUS, v, rdy);
        check("held_read_count", v, 32'h0000_0101);

        // Flush
        send_and_model(8'h33, 1'b1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, v, rdy);
        check("flush_status", v, 32'h0);

        // Coincident push and pop: find the push edge, then pop on it
        align_tick();
        n = 0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int i = 1; i < 360; i++) begin
                    @(negedge clk);
                    if (rx_avail && n == 0) n = i;
                end
            end
        join
        model_frame(8'h5A, 1'b1);
        check("push_latency_found", {31'h0, n != 0}, 32'h1);
        if (n > 1) begin
            align_tick();
            fork
                send_frame(8'h77, 1'b1);
                begin
                    repeat (n - 1) @(negedge clk);
                    address = A_DATA;
                    r_w     = 1'b0;
                    request = 1'b1;
                    #1;
                    v = data;
                    @(negedge clk);
                    request = 1'b0;
                end
            join
            check("coincident_pop_value", v, 32'h0000_005A);
            void'(q.pop_front());
            model_frame(8'h77, 1'b1);
            bus_read(A_STATUS, v, rdy);
            check("coincident_count_unchanged", v, 32'h0000_0101);
            read_data_chk("coincident_second_byte");
        end

        // Reset mid-frame with bytes and flags pending
        send_and_model(8'h44, 1'b1);
        send_and_model(8'h99, 1'b0);
        repeat (bit_clocks(0)) @(negedge clk);
        RxD = 1'b0;
        repeat (3 * bit_clocks(0)) @(negedge clk);
        clr = 1'b0;
        RxD = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        repeat (10) @(negedge clk);
        check("midframe_reset_rx_avail", {31'h0, rx_avail}, 32'h0);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, v, rdy);
        check("midframe_reset_status", v, 32'h0);
        send_and_model(8'h3C, 1'b1);
        read_status_chk("after_reset_status");
        bus_read(A_DATA, v, rdy);
        check("after_reset_data", v, 32'h0000_003C);
        void'(q.pop_front());

        // Randomised frames and bus operations against the model
        for (int it = 0; it < 24; it++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_and_model(b, stop);
            if (!stop) repeat (bit_clocks(0)) @(negedge clk);
            for (int op = 0; op < int'($urandom_range(0, 2)); op++) begin
                case ($urandom_range(0, 3))
                    0: read_data_chk($sformatf("rand%0d_data", it));
                    1: read_status_chk($sformatf("rand%0d_status_op", it));
                    2: if ($urandom_range(0, 3) == 0) bus_write(A_CTRL, 32'($urandom_range(0, 3)));
                    default: bus_write(A_DATA, $urandom);
                endcase
            end
            read_status_chk($sformatf("rand%0d_status", it));
        end
        while (q.size() != 0) read_data_chk("rand_drain");
        read_status_chk("rand_final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
